proc_mem_responder: RTL
=======================

Name: proc_mem_responder

Overview:
- Responder end of the processor's instruction and data memory interfaces.
- Word-addressed, byte-address-decoded memory with one instruction read port and one data read/write port.
- Reads are combinational, same cycle as the request; writes commit at the clock edge.
- Also provides a load port so the bench can preload programs while the processor is held in reset, a sticky error tracker, and saturating access counters.

Parameters:
- NUM_WORDS, 256, number of 32-bit words; must be a power of two, 2..65536.
- AW, $clog2(NUM_WORDS), derived word-index width; not to be overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imemreq_val  in  1  instruction fetch request valid
- imemreq_addr  in  32  fetch byte address
- imemresp_data  out  32  fetch data, same cycle
- dmemreq_val  in  1  data request valid
- dmemreq_type  in  1  0 = read, 1 = write
- dmemreq_addr  in  32  data byte address
- dmemreq_wdata  in  32  store data
- dmemresp_rdata  out  32  load data, same cycle
- load_en  in  1  bench preload write enable
- load_addr  in  32  preload byte address
- load_data  in  32  preload word
- err  out  1  sticky access-error flag
- err_addr  out  32  byte address of the first error
- imem_count  out  32  accepted fetches
- dmem_rd_count  out  32  accepted loads
- dmem_wr_count  out  32  accepted stores

Behaviour:
- Synchronous active-high reset: single clock clk, reset rst.
- Reset values:
  - err = 0, err_addr = 0, all counters = 0.
  - imemresp_data and dmemresp_rdata are forced to 0 while rst = 1.
  - Memory contents are NOT cleared.
- Decode, applied to every port:
  - Word index = addr[AW+1:2].
  - A request is legal iff addr[1:0] == 0 and addr < NUM_WORDS*4.
- Fetch:
  - When imemreq_val = 1 and the address is legal, imemresp_data = mem[index] combinationally.
  - Otherwise imemresp_data = 0.
- Data read:
  - When dmemreq_val = 1, dmemreq_type = 0 and the address is legal, dmemresp_rdata = mem[index] combinationally.
  - Otherwise dmemresp_rdata = 0. This includes writes: the response is 0 during a write.
- Data write:
  - When dmemreq_val = 1, dmemreq_type = 1, the address is legal and rst = 0, mem[index] <= dmemreq_wdata at the rising edge.
  - Illegal writes are dropped; memory is unchanged.
- Load port:
  - When load_en = 1 and the address is legal, mem[index] <= load_data at the edge. This applies regardless of rst.
  - An illegal load_addr is ignored and does not set err.
- Read-during-write: a fetch or read to a word written in the same cycle returns the OLD value; the new value is visible from the next cycle.
- Simultaneous load and data write to the same word: load_en wins. To different words, both commit.
- Error tracker, two states:
  - OK -> ERR on the first edge with rst = 0 where any valid imem/dmem request is illegal.
  - On that transition err_addr captures the offending address, with dmem taking priority over imem in the same cycle.
  - ERR holds err_addr; later errors do not overwrite it.
  - ERR -> OK only on rst.
- Counters:
  - Each increments by 1 per edge where rst = 0 and the matching request is valid and legal.
  - Counters saturate at 32'hFFFFFFFF; no wrap.
  - imem_count counts valid legal fetches; dmem_rd_count and dmem_wr_count split by dmemreq_type.
- Timing: zero-cycle read latency and no stall or backpressure signals, because the pipeline assumes single-cycle memory.

Decomposition:
- Shared package:
  - MEM_REQ_READ = 1'b0, MEM_REQ_WRITE = 1'b1.
  - Error-state enum {MEM_ERR_OK, MEM_ERR_SET}.
  - Default NUM_WORDS.
- One sub-module: sat_counter.
  - Parameter W.
  - Inputs clk, rst, inc; output count.
  - Saturating increment with synchronous clear.
  - Instantiated three times.
- The address-legality check is a function in the package, shared by the three ports.

Test Plan:
- Preload under reset: rst = 1, load 0x00000013 at 0x0 and 0x00100093 at 0x4; release rst; fetch 0x4 -> imemresp_data = 0x00100093; imem_count = 1 after the edge.
- Store then load: write 0xDEADBEEF to 0x100; the same-cycle fetch of 0x100 returns the old value; a read of 0x100 next cycle -> 0xDEADBEEF; dmem_wr_count = 1, dmem_rd_count = 1.
- Illegal accesses:
  - Read 0x102 -> rdata = 0, err = 1, err_addr = 0x102.
  - A later write to 0x400 (out of range, NUM_WORDS = 256) is dropped; err_addr stays 0x102; no counter increments.
- Conflict: load_en to 0x20 with 0x11111111 and dmem write to 0x20 with 0x22222222 in the same cycle -> mem[8] = 0x11111111.
- Saturation: force dmem_rd_count near max (or use W = 4 in a sat_counter unit bench); 20 increments -> count = 0xF and holds.
- Mid-operation reset: assert rst while a write to 0x8 is valid:
  - The write is dropped, counters and err clear, and the responses read 0 while rst = 1.
  - Memory at 0x0 retains its preload.

Source files
------------

// File: rtl/proc_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_mem_responder_pkg
// Description : Shared request encodings, error-state type and address decode
//               for the processor memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_mem_responder_pkg;

    localparam int DEFAULT_NUM_WORDS = 256;

    localparam logic MEM_REQ_READ  = 1'b0;
    localparam logic MEM_REQ_WRITE = 1'b1;

    typedef enum logic [0:0] {
        MEM_ERR_OK  = 1'b0,
        MEM_ERR_SET = 1'b1
    } mem_err_state_e;

    // Word-aligned and inside the array; widened so NUM_WORDS*4 cannot overflow.
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input int unsigned num_words);
        logic [33:0] w_limit;
        w_limit = 34'(num_words) << 2;
        return (addr[1:0] == 2'b00) && ({2'b00, addr} < w_limit);
    endfunction

endpackage : proc_mem_responder_pkg
`default_nettype wire

// File: rtl/proc_mem_responder_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that holds at all-ones, with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] c_max = {W{1'b1}};
    localparam logic [W-1:0] c_one = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/proc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : proc_mem_responder
// Description : Single-cycle instruction/data memory responder with preload
//               port, sticky error capture and saturating access counters.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_mem_responder
    import proc_mem_responder_pkg::*;
#(
    parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
    parameter int AW        = $clog2(NUM_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemreq_val,
    input  logic [31:0] imemreq_addr,
    output logic [31:0] imemresp_data,
    input  logic        dmemreq_val,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    output logic [31:0] dmemresp_rdata,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        err,
    output logic [31:0] err_addr,
    output logic [31:0] imem_count,
    output logic [31:0] dmem_rd_count,
    output logic [31:0] dmem_wr_count
);

    logic [31:0] r_mem [NUM_WORDS];

    mem_err_state_e r_err_state;
    logic [31:0]    r_err_addr;

    logic          w_imem_legal;
    logic          w_dmem_legal;
    logic          w_load_legal;
    logic [AW-1:0] w_imem_idx;
    logic [AW-1:0] w_dmem_idx;
    logic [AW-1:0] w_load_idx;
    logic          w_imem_ok;
    logic          w_dmem_rd_ok;
    logic          w_dmem_wr_ok;
    logic          w_load_ok;
    logic          w_imem_err;
    logic          w_dmem_err;

    assign w_imem_legal = addr_legal(imemreq_addr, NUM_WORDS);
    assign w_dmem_legal = addr_legal(dmemreq_addr, NUM_WORDS);
    assign w_load_legal = addr_legal(load_addr, NUM_WORDS);

    assign w_imem_idx = imemreq_addr[AW+1:2];
    assign w_dmem_idx = dmemreq_addr[AW+1:2];
    assign w_load_idx = load_addr[AW+1:2];

    assign w_imem_ok    = imemreq_val && w_imem_legal;
    assign w_dmem_rd_ok = dmemreq_val && (dmemreq_type == MEM_REQ_READ)  && w_dmem_legal;
    assign w_dmem_wr_ok = dmemreq_val && (dmemreq_type == MEM_REQ_WRITE) && w_dmem_legal;
    assign w_load_ok    = load_en && w_load_legal;

    assign w_imem_err = imemreq_val && !w_imem_legal;
    assign w_dmem_err = dmemreq_val && !w_dmem_legal;

    // Reads see the pre-edge contents, so read-during-write returns old data.
    assign imemresp_data  = (!rst && w_imem_ok)    ? r_mem[w_imem_idx] : '0;
    assign dmemresp_rdata = (!rst && w_dmem_rd_ok) ? r_mem[w_dmem_idx] : '0;

    // The load write is issued last so it overrides a store to the same word.
    always_ff @(posedge clk) begin
        if (w_dmem_wr_ok && !rst) begin
            r_mem[w_dmem_idx] <= dmemreq_wdata;
        end
        if (w_load_ok) begin
            r_mem[w_load_idx] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_state <= MEM_ERR_OK;
            r_err_addr  <= '0;
        end else begin
            case (r_err_state)
                MEM_ERR_OK: begin
                    if (w_dmem_err || w_imem_err) begin
                        r_err_state <= MEM_ERR_SET;
                        r_err_addr  <= w_dmem_err ? dmemreq_addr : imemreq_addr;
                    end
                end
                MEM_ERR_SET: begin
                    r_err_state <= MEM_ERR_SET;
                end
                default: begin
                    r_err_state <= MEM_ERR_OK;
                end
            endcase
        end
    end

    assign err      = (r_err_state == MEM_ERR_SET);
    assign err_addr = r_err_addr;

    sat_counter #(.W(32)) u_imem_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_imem_ok),
        .count (imem_count)
    );

    sat_counter #(.W(32)) u_dmem_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_dmem_rd_ok),
        .count (dmem_rd_count)
    );

    sat_counter #(.W(32)) u_dmem_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_dmem_wr_ok),
        .count (dmem_wr_count)
    );

endmodule : proc_mem_responder
`default_nettype wire
